// File: rtl/core_types.sv
// Shared commit/redirect types: redirect causes and commit redirect FSM states.
package core_types;

    typedef enum logic [2:0] {
        RDR_NONE,
        RDR_EXCP,
        RDR_ERTN,
        RDR_REFETCH,
        RDR_IDLE_WAKE
    } redirect_cause_e;

    typedef enum logic [1:0] {
        CR_RUN,
        CR_DRAIN,
        CR_IDLE
    } commit_redirect_state_e;

    // Wide enough for drain windows of 1..15 cycles.
    localparam int DRAIN_CNT_W = 4;

endpackage

// File: rtl/commit_redirect_ctrl.sv
// Commit redirect controller: turns one-cycle commit flush pulses into a single
// registered frontend redirect, runs the IDLE wait state and the post-flush
// drain window during which dispatch is held while the pipes empty.
module commit_redirect_ctrl
    import core_types::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int PC_W         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            excp_flush_i,
    input  logic            excp_tlbrefill_i,
    input  logic            ertn_flush_i,
    input  logic            idle_flush_i,
    input  logic            fetch_flush_i,
    input  logic            icache_flush_i,
    input  logic [PC_W-1:0] commit_pc_i,
    input  logic [PC_W-1:0] csr_era_i,
    input  logic [PC_W-1:0] csr_eentry_i,
    input  logic [PC_W-1:0] csr_tlbrentry_i,
    input  logic            int_pending_i,
    output logic            redirect_valid_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic            frontend_hold_o,
    output logic            backend_hold_o,
    output logic            idle_state_o
);

    commit_redirect_state_e   state;
    logic [DRAIN_CNT_W-1:0]   drain_cnt;
    logic [PC_W-1:0]          idle_pc;
    logic [PC_W-1:0]          pc_plus4;
    redirect_cause_e          cause;
    logic                     enter_idle;
    logic [PC_W-1:0]          target;

    assign pc_plus4 = commit_pc_i + PC_W'(4);

    // Priority-encode this cycle's flush inputs; IDLE only listens to exceptions and interrupts.
    always_comb begin
        cause      = RDR_NONE;
        enter_idle = 1'b0;
        case (state)
            CR_IDLE: begin
                if (excp_flush_i) begin
                    cause = RDR_EXCP;
                end else if (int_pending_i) begin
                    cause = RDR_IDLE_WAKE;
                end
            end
            default: begin
                if (excp_flush_i) begin
                    cause = RDR_EXCP;
                end else if (ertn_flush_i) begin
                    cause = RDR_ERTN;
                end else if (idle_flush_i) begin
                    enter_idle = 1'b1;
                end else if (fetch_flush_i || icache_flush_i) begin
                    cause = RDR_REFETCH;
                end
            end
        endcase
    end

    // Select the redirect target for the winning cause.
    always_comb begin
        target = '0;
        case (cause)
            RDR_EXCP:      target = excp_tlbrefill_i ? csr_tlbrentry_i : csr_eentry_i;
            RDR_ERTN:      target = csr_era_i;
            RDR_REFETCH:   target = pc_plus4;
            RDR_IDLE_WAKE: target = idle_pc;
            default:       target = '0;
        endcase
    end

    // FSM with registered redirect/hold outputs, drain counter and idle wake-pc latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= CR_RUN;
            drain_cnt        <= '0;
            idle_pc          <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            frontend_hold_o  <= 1'b0;
            backend_hold_o   <= 1'b0;
            idle_state_o     <= 1'b0;
        end else begin
            redirect_valid_o <= 1'b0;
            if (cause != RDR_NONE) begin
                state            <= CR_DRAIN;
                drain_cnt        <= DRAIN_CNT_W'(DRAIN_CYCLES);
                redirect_valid_o <= 1'b1;
                redirect_pc_o    <= target;
                frontend_hold_o  <= 1'b0;
                backend_hold_o   <= 1'b1;
                idle_state_o     <= 1'b0;
            end else if (enter_idle) begin
                state            <= CR_IDLE;
                drain_cnt        <= '0;
                idle_pc          <= pc_plus4;
                frontend_hold_o  <= 1'b1;
                backend_hold_o   <= 1'b1;
                idle_state_o     <= 1'b1;
            end else if (state == CR_DRAIN) begin
                if (drain_cnt <= DRAIN_CNT_W'(1)) begin
                    state          <= CR_RUN;
                    drain_cnt      <= '0;
                    backend_hold_o <= 1'b0;
                end else begin
                    drain_cnt <= drain_cnt - DRAIN_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_redirect_ctrl.sv
// Self-checking bench for commit_redirect_ctrl: directed vector table, hand-written
// IDLE/reset sequences and randomized traffic against a behavioural model.
module tb_commit_redirect_ctrl;

    localparam int DRAIN = 2;

    typedef struct {
        bit          excp;
        bit          tlb;
        bit          ertn;
        bit          idle;
        bit          fetch;
        bit          icache;
        bit          intp;
        logic [31:0] pc;
        logic [31:0] era;
        logic [31:0] eentry;
        logic [31:0] tlbr;
    } in_t;

    typedef struct {
        logic [5:0]  fl;
        bit          intp;
        logic [31:0] pc;
        logic [31:0] era;
        bit          ev;
        logic [31:0] epc;
        logic [2:0]  eh;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        excp_flush, excp_tlbrefill, ertn_flush, idle_flush, fetch_flush, icache_flush;
    logic [31:0] commit_pc, csr_era, csr_eentry, csr_tlbrentry;
    logic        int_pending;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        frontend_hold, backend_hold, idle_state;

    int tests_run    = 0;
    int tests_failed = 0;

    int          m_drain;
    bit          m_idle;
    logic [31:0] m_idle_pc;
    bit          exp_valid;
    logic [31:0] exp_pc;

    vec_t tbl[20];
    in_t  quiet;

    commit_redirect_ctrl #(.DRAIN_CYCLES(DRAIN), .PC_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .excp_flush_i     (excp_flush),
        .excp_tlbrefill_i (excp_tlbrefill),
        .ertn_flush_i     (ertn_flush),
        .idle_flush_i     (idle_flush),
        .fetch_flush_i    (fetch_flush),
        .icache_flush_i   (icache_flush),
        .commit_pc_i      (commit_pc),
        .csr_era_i        (csr_era),
        .csr_eentry_i     (csr_eentry),
        .csr_tlbrentry_i  (csr_tlbrentry),
        .int_pending_i    (int_pending),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .frontend_hold_o  (frontend_hold),
        .backend_hold_o   (backend_hold),
        .idle_state_o     (idle_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        excp_flush     = v.excp;
        excp_tlbrefill = v.tlb;
        ertn_flush     = v.ertn;
        idle_flush     = v.idle;
        fetch_flush    = v.fetch;
        icache_flush   = v.icache;
        int_pending    = v.intp;
        commit_pc      = v.pc;
        csr_era        = v.era;
        csr_eentry     = v.eentry;
        csr_tlbrentry  = v.tlbr;
    endtask

    // Behavioural model: one call per clock with the inputs seen in that cycle.
    task automatic model_redirect(input logic [31:0] t);
        exp_valid = 1'b1;
        exp_pc    = t;
        m_drain   = DRAIN;
        m_idle    = 1'b0;
    endtask

    task automatic model_step(input in_t v);
        logic [31:0] excp_t;
        logic [31:0] next_pc;
        excp_t    = v.tlb ? v.tlbr : v.eentry;
        next_pc   = v.pc + 32'd4;
        exp_valid = 1'b0;
        if (m_idle) begin
            if (v.excp)      model_redirect(excp_t);
            else if (v.intp) model_redirect(m_idle_pc);
        end else if (v.excp) begin
            model_redirect(excp_t);
        end else if (v.ertn) begin
            model_redirect(v.era);
        end else if (v.idle) begin
            m_idle    = 1'b1;
            m_idle_pc = next_pc;
            m_drain   = 0;
        end else if (v.fetch || v.icache) begin
            model_redirect(next_pc);
        end else if (m_drain > 0) begin
            m_drain--;
        end
    endtask

    task automatic model_reset();
        m_drain   = 0;
        m_idle    = 1'b0;
        m_idle_pc = '0;
        exp_valid = 1'b0;
        exp_pc    = '0;
    endtask

    task automatic check_model(input string tag);
        check_output({tag, " valid"}, {31'd0, redirect_valid}, {31'd0, exp_valid});
        if (exp_valid) check_output({tag, " pc"}, redirect_pc, exp_pc);
        check_output({tag, " frontend_hold"}, {31'd0, frontend_hold}, {31'd0, m_idle});
        check_output({tag, " backend_hold"}, {31'd0, backend_hold}, {31'd0, (m_idle || m_drain > 0)});
        check_output({tag, " idle_state"}, {31'd0, idle_state}, {31'd0, m_idle});
    endtask

    // One clock: drive inputs away from the edge, advance, sample #1 after the edge.
    task automatic apply_stimulus(input in_t v);
        drive(v);
        @(posedge clk);
        #1;
        model_step(v);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " valid"}, {31'd0, redirect_valid}, 32'd0);
        check_output({tag, " pc"}, redirect_pc, 32'd0);
        check_output({tag, " holds"}, {29'd0, frontend_hold, backend_hold, idle_state}, 32'd0);
    endtask

    task automatic do_reset();
        drive(quiet);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        in_t v;
        quiet = '{excp: 0, tlb: 0, ertn: 0, idle: 0, fetch: 0, icache: 0, intp: 0,
                  pc: 32'h1C00_0000, era: 32'h1C00_0100, eentry: 32'h1C00_8000, tlbr: 32'h1C00_F000};

        // fl = {excp, tlbrefill, ertn, idle, fetch, icache}; eh = {frontend, backend, idle_state}
        tbl[0]  = '{6'b100000, 0, 32'h0,         32'h1C00_0100, 1, 32'h1C00_8000, 3'b010};
        tbl[1]  = '{6'b000000, 0, 32'h0,         32'h1C00_0100, 0, 32'h0,         3'b010};
        tbl[2]  = '{6'b000000, 0, 32'h0,         32'h1C00_0100, 0, 32'h0,         3'b000};
        tbl[3]  = '{6'b000000, 0, 32'h0,         32'h1C00_0100, 0, 32'h0,         3'b000};
        tbl[4]  = '{6'b111000, 0, 32'h0,         32'h1C00_0100, 1, 32'h1C00_F000, 3'b010};
        tbl[5]  = '{6'b000000, 0, 32'h0,         32'h1C00_0100, 0, 32'h0,         3'b010};
        tbl[6]  = '{6'b000000, 0, 32'h0,         32'h1C00_0100, 0, 32'h0,         3'b000};
        tbl[7]  = '{6'b000010, 0, 32'hFFFF_FFFC, 32'h1C00_0100, 1, 32'h0,         3'b010};
        tbl[8]  = '{6'b000000, 0, 32'h0,         32'h1C00_0100, 0, 32'h0,         3'b010};
        tbl[9]  = '{6'b000000, 0, 32'h0,         32'h1C00_0100, 0, 32'h0,         3'b000};
        tbl[10] = '{6'b001000, 0, 32'h0,         32'h0000_0100, 1, 32'h0000_0100, 3'b010};
        tbl[11] = '{6'b000000, 0, 32'h0,         32'h0000_0100, 0, 32'h0,         3'b010};
        tbl[12] = '{6'b000001, 0, 32'h0000_0300, 32'h0000_0100, 1, 32'h0000_0304, 3'b010};
        tbl[13] = '{6'b000000, 0, 32'h0,         32'h0000_0100, 0, 32'h0,         3'b010};
        tbl[14] = '{6'b000000, 0, 32'h0,         32'h0000_0100, 0, 32'h0,         3'b000};
        tbl[15] = '{6'b000110, 0, 32'h0000_0500, 32'h0000_0100, 0, 32'h0,         3'b111};
        tbl[16] = '{6'b001000, 0, 32'h0000_0700, 32'h0000_0100, 0, 32'h0,         3'b111};
        tbl[17] = '{6'b000000, 1, 32'h0000_0900, 32'h0000_0100, 1, 32'h0000_0504, 3'b010};
        tbl[18] = '{6'b000000, 1, 32'h0,         32'h0000_0100, 0, 32'h0,         3'b010};
        tbl[19] = '{6'b000000, 0, 32'h0,         32'h0000_0100, 0, 32'h0,         3'b000};

        rst = 1'b1;
        drive(quiet);
        #2;
        do_reset();

        // Directed vector table, checked against hand-derived constants.
        for (int i = 0; i < 20; i++) begin
            v        = quiet;
            v.excp   = tbl[i].fl[5];
            v.tlb    = tbl[i].fl[4];
            v.ertn   = tbl[i].fl[3];
            v.idle   = tbl[i].fl[2];
            v.fetch  = tbl[i].fl[1];
            v.icache = tbl[i].fl[0];
            v.intp   = tbl[i].intp;
            v.pc     = tbl[i].pc;
            v.era    = tbl[i].era;
            drive(v);
            @(posedge clk);
            #1;
            check_output($sformatf("tbl%0d valid", i), {31'd0, redirect_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) check_output($sformatf("tbl%0d pc", i), redirect_pc, tbl[i].epc);
            check_output($sformatf("tbl%0d holds", i),
                         {29'd0, frontend_hold, backend_hold, idle_state}, {29'd0, tbl[i].eh});
        end

        // Long IDLE wait, then interrupt wake to the latched pc+4.
        do_reset();
        v = quiet; v.idle = 1; v.pc = 32'h1C00_0200;
        apply_stimulus(v);
        check_model("idle_enter");
        for (int i = 0; i < 20; i++) begin
            v = quiet; v.pc = 32'h2000_0000 + 32'(i * 16);
            apply_stimulus(v);
            check_model($sformatf("idle_wait%0d", i));
        end
        v = quiet; v.intp = 1;
        apply_stimulus(v);
        check_output("wake pc", redirect_pc, 32'h1C00_0204);
        check_model("wake");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(quiet);
            check_model($sformatf("wake_drain%0d", i));
        end

        // Exception beats a simultaneous interrupt while idle.
        v = quiet; v.idle = 1; v.pc = 32'h1C00_0400;
        apply_stimulus(v);
        v = quiet; v.excp = 1; v.intp = 1; v.tlb = 1;
        apply_stimulus(v);
        check_model("idle_excp");
        repeat (2) apply_stimulus(quiet);

        // Asynchronous reset in the middle of IDLE.
        v = quiet; v.idle = 1; v.pc = 32'h1C00_0600;
        apply_stimulus(v);
        check_model("pre_async_reset");
        #3;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        apply_stimulus(quiet);
        check_model("post_reset_quiet");
        v = quiet; v.fetch = 1; v.pc = 32'h1C00_0800;
        apply_stimulus(v);
        check_model("post_reset_fetch");

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v.excp   = ($urandom_range(15) == 0);
            v.tlb    = $urandom_range(1) != 0;
            v.ertn   = ($urandom_range(11) == 0);
            v.idle   = ($urandom_range(13) == 0);
            v.fetch  = ($urandom_range(11) == 0);
            v.icache = ($urandom_range(11) == 0);
            v.intp   = ($urandom_range(5) == 0);
            v.pc     = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
            v.era    = $urandom;
            v.eentry = $urandom;
            v.tlbr   = $urandom;
            apply_stimulus(v);
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
